// File: rtl/spi_burst_pkg.sv
// Purpose : shared types and constants for the spi_burst SPI burst engine.
// Contents: FSM state encoding, SPI word width, default FIFO depth, level width,
//           and the packed TX FIFO entry {fast, data}.
package spi_burst_pkg;

   // Width of one SPI word as seen by both the host and the shifter.
   localparam int unsigned WORD_W        = 32;

   // Default FIFO entries per direction (power of two, 2..64).
   localparam int unsigned DEPTH_DEFAULT = 8;

   // Level outputs must represent 0..64 inclusive, hence 7 bits.
   localparam int unsigned LEVEL_W       = 7;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,   // waiting for a queued word and an idle shifter
      ST_ISSUE   = 2'd1,   // single-cycle spi_start strobe
      ST_WAIT_LO = 2'd2,   // waiting for the shifter to drop spi_rdy
      ST_WAIT_HI = 2'd3    // waiting for the shifter to raise spi_rdy (done)
   } state_t;

   // One TX FIFO entry: mode flag above the data word (1 = 32-bit, 0 = 8-bit).
   typedef struct packed {
      logic              fast;
      logic [WORD_W-1:0] dat;
   } tx_word_t;

endpackage

// File: rtl/spi_burst_fifo.sv
// Purpose : synchronous FIFO with occupancy level and a one-cycle flush.
// Latency : a pushed word is visible at head_dat the cycle after the push edge.
// Backpr. : push ignored while full, pop ignored while empty; flush beats push.
// Ports   : clk/rst (sync, active-high), flush, push_vld/push_dat, pop_rdy,
//           full, empty, head_dat (zero when empty), level (0..DEPTH).
module spi_burst_fifo
   import spi_burst_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               push_vld,
   input  logic [WIDTH-1:0]   push_dat,
   input  logic               pop_rdy,
   output logic               full,
   output logic               empty,
   output logic [WIDTH-1:0]   head_dat,
   output logic [LEVEL_W-1:0] level
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0]   mem_q [DEPTH];
   logic [WIDTH-1:0]   mem_d [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [LEVEL_W-1:0] level_q, level_d;
   logic               push_acc;
   logic               pop_acc;

   assign full     = (level_q == LEVEL_W'(DEPTH));
   assign empty    = (level_q == '0);
   assign push_acc = push_vld && !full;
   assign pop_acc  = pop_rdy && !empty;
   assign level    = level_q;
   assign head_dat = empty ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;

      if (push_acc) begin
         mem_d[wr_ptr_q] = push_dat;
         // DEPTH is a power of two, so the natural pointer wrap is modulo DEPTH.
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop_acc) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end

      unique case ({push_acc, pop_acc})
         2'b10:   level_d = level_q + LEVEL_W'(1);
         2'b01:   level_d = level_q - LEVEL_W'(1);
         default: level_d = level_q;
      endcase

      // Flush empties the FIFO outright; stale storage is left in place since
      // it is unreachable once the pointers are equal and the level is zero.
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage needs no reset: nothing reads it while the level is zero.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/spi_burst.sv
// Purpose : queues host words in a TX FIFO, issues them one at a time to an
//           external SPI shifter and (optionally) queues replies in an RX FIFO.
// Latency : a word written in cycle N can raise spi_start in cycle N+2; after a
//           transfer completes the next spi_start is no earlier than 2 edges later.
// Backpr. : tx_ready drops when the TX FIFO is full; with the RX FIFO built, a
//           full RX FIFO stalls issue; rx_valid/rx_ready pop the RX FIFO.
// Ports   : clk, rst (sync, active-high); host TX tx_valid/tx_ready/tx_data/
//           tx_fast; host RX rx_valid/rx_ready/rx_data; flush; status busy,
//           tx_level, rx_level; shifter spi_start/spi_fast/spi_dataTx/
//           spi_dataRx/spi_rdy.
// Config  : define SPI_BURST_RXFIFO_EN to build the RX FIFO; otherwise replies
//           are dropped and rx_valid, rx_data and rx_level are tied to zero.
module spi_burst
   import spi_burst_pkg::*;
#(
   parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
   input  logic               clk,
   input  logic               rst,
   // host write channel
   input  logic               tx_valid,
   output logic               tx_ready,
   input  logic [WORD_W-1:0]  tx_data,
   input  logic               tx_fast,
   // host read channel
   output logic               rx_valid,
   input  logic               rx_ready,
   output logic [WORD_W-1:0]  rx_data,
   // control and status
   input  logic               flush,
   output logic               busy,
   output logic [LEVEL_W-1:0] tx_level,
   output logic [LEVEL_W-1:0] rx_level,
   // SPI shifter side
   output logic               spi_start,
   output logic               spi_fast,
   output logic [WORD_W-1:0]  spi_dataTx,
   input  logic [WORD_W-1:0]  spi_dataRx,
   input  logic               spi_rdy
);

   state_t             state_q, state_d;
   logic               spi_fast_q, spi_fast_d;
   logic [WORD_W-1:0]  spi_data_tx_q, spi_data_tx_d;
   // Set when a flush hits an in-flight transfer so its reply is discarded.
   logic               drop_q, drop_d;

   tx_word_t           tx_in;
   tx_word_t           tx_head;
   logic               tx_full;
   logic               tx_empty;
   logic               tx_pop;
   logic               rx_push;
   logic               rx_full;

   // ------------------------------------------------------------------
   // TX FIFO
   // ------------------------------------------------------------------
   assign tx_in.fast = tx_fast;
   assign tx_in.dat  = tx_data;
   assign tx_ready   = !tx_full;

   spi_burst_fifo #(
      .WIDTH ($bits(tx_word_t)),
      .DEPTH (DEPTH)
   ) u_tx_fifo (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .push_vld (tx_valid),
      .push_dat (tx_in),
      .pop_rdy  (tx_pop),
      .full     (tx_full),
      .empty    (tx_empty),
      .head_dat (tx_head),
      .level    (tx_level)
   );

   // ------------------------------------------------------------------
   // RX FIFO (optional)
   // ------------------------------------------------------------------
`ifdef SPI_BURST_RXFIFO_EN
   logic rx_empty;

   spi_burst_fifo #(
      .WIDTH (WORD_W),
      .DEPTH (DEPTH)
   ) u_rx_fifo (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .push_vld (rx_push),
      .push_dat (spi_dataRx),
      .pop_rdy  (rx_ready),
      .full     (rx_full),
      .empty    (rx_empty),
      .head_dat (rx_data),
      .level    (rx_level)
   );

   assign rx_valid = !rx_empty;
`else
   // No reply storage: never stall on it and present an empty read channel.
   assign rx_full  = 1'b0;
   assign rx_valid = 1'b0;
   assign rx_data  = '0;
   assign rx_level = '0;

   logic unused_rx;
   assign unused_rx = &{1'b0, rx_ready, rx_push, spi_dataRx};
`endif

   // ------------------------------------------------------------------
   // Issue FSM
   // ------------------------------------------------------------------
   always_comb begin
      state_d       = state_q;
      spi_fast_d    = spi_fast_q;
      spi_data_tx_d = spi_data_tx_q;
      drop_d        = drop_q;
      tx_pop        = 1'b0;
      rx_push       = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            drop_d = 1'b0;
            // A flush in the same cycle empties the TX FIFO, so do not pop
            // a word that is being discarded.
            if (!tx_empty && spi_rdy && !rx_full && !flush) begin
               tx_pop        = 1'b1;
               spi_fast_d    = tx_head.fast;
               spi_data_tx_d = tx_head.dat;
               state_d       = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            state_d = ST_WAIT_LO;
         end
         ST_WAIT_LO: begin
            if (!spi_rdy) begin
               state_d = ST_WAIT_HI;
            end
         end
         ST_WAIT_HI: begin
            if (spi_rdy) begin
               state_d = ST_IDLE;
               // Flush on the completing edge wins over the reply push.
               rx_push = !flush && !drop_q;
               drop_d  = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Flush during a transfer that is not completing now: remember to
      // discard its reply when the shifter finishes.
      if (flush && (state_d != ST_IDLE)) begin
         drop_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         spi_fast_q    <= 1'b0;
         spi_data_tx_q <= '0;
         drop_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         spi_fast_q    <= spi_fast_d;
         spi_data_tx_q <= spi_data_tx_d;
         drop_q        <= drop_d;
      end
   end

   // spi_start is a Moore output of ISSUE, so it is high for exactly one cycle.
   assign spi_start  = (state_q == ST_ISSUE);
   assign spi_fast   = spi_fast_q;
   assign spi_dataTx = spi_data_tx_q;
   assign busy       = (state_q != ST_IDLE) || !tx_empty;

endmodule

// File: tb/tb_spi_burst.sv
// Purpose : directed self-checking bench for spi_burst (DEPTH = 8).
// Flow    : written words go to a scoreboard queue; each spi_start pops one and
//           compares the issued word; status checks cover reset, flush, stalls.
// Config  : follows SPI_BURST_RXFIFO_EN the same way as the design.
module tb_spi_burst;

   logic        clk;
   logic        rst;
   logic        tx_valid;
   logic        tx_ready;
   logic [31:0] tx_data;
   logic        tx_fast;
   logic        rx_valid;
   logic        rx_ready;
   logic [31:0] rx_data;
   logic        flush;
   logic        busy;
   logic [6:0]  tx_level;
   logic [6:0]  rx_level;
   logic        spi_start;
   logic        spi_fast;
   logic [31:0] spi_dataTx;
   logic [31:0] spi_dataRx;
   logic        spi_rdy;

   int          n_chk   = 0;
   int          n_err   = 0;
   int          n_pulse = 0;
   int          last_wait;
   bit          start_seen;
   logic [32:0] cur_exp;
   logic [32:0] sb_q [$];

   spi_burst #(.DEPTH(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .tx_data    (tx_data),
      .tx_fast    (tx_fast),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .rx_data    (rx_data),
      .flush      (flush),
      .busy       (busy),
      .tx_level   (tx_level),
      .rx_level   (rx_level),
      .spi_start  (spi_start),
      .spi_fast   (spi_fast),
      .spi_dataTx (spi_dataTx),
      .spi_dataRx (spi_dataRx),
      .spi_rdy    (spi_rdy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counts spi_start cycles, sampled away from the active edge.
   always @(negedge clk) begin
      if (spi_start === 1'b1) n_pulse++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Single host write into a FIFO that is expected to have room.
   task automatic wr(input logic [31:0] d, input logic f);
      chk("wr_ready", tx_ready, 1'b1);
      tx_valid = 1'b1;
      tx_data  = d;
      tx_fast  = f;
      sb_q.push_back({f, d});
      step();
      tx_valid = 1'b0;
   endtask

   // Waits (bounded) for spi_start, then checks the issued word against the
   // oldest scoreboard entry.
   task automatic wait_issue(input string tag);
      int k = 0;
      while (spi_start !== 1'b1 && k < 50) begin
         step();
         k++;
      end
      last_wait  = k;
      start_seen = (spi_start === 1'b1);
      chk({tag, "_start"}, spi_start, 1'b1);
      if (start_seen) begin
         n_chk++;
         assert (sb_q.size() > 0) else begin
            n_err++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
         end
         if (sb_q.size() > 0) begin
            cur_exp = sb_q.pop_front();
            chk({tag, "_word"}, {spi_fast, spi_dataTx}, cur_exp);
         end
      end
   endtask

   // One complete shifter handshake: spi_rdy low for lo_cycles+1, then high
   // with the reply word. Returns with the FSM back in IDLE.
   task automatic xfer(input string tag, input logic [31:0] reply, input int lo_cycles);
      wait_issue(tag);
      if (!start_seen) return;
      spi_rdy = 1'b0;
      step();
      chk({tag, "_one_cycle"}, spi_start, 1'b0);
      repeat (lo_cycles) step();
      chk({tag, "_hold"}, {spi_fast, spi_dataTx}, cur_exp);
      spi_dataRx = reply;
      spi_rdy    = 1'b1;
      step();
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_start"},    spi_start,  1'b0);
      chk({tag, "_fast"},     spi_fast,   1'b0);
      chk({tag, "_dataTx"},   spi_dataTx, 32'h0);
      chk({tag, "_tx_ready"}, tx_ready,   1'b1);
      chk({tag, "_rx_valid"}, rx_valid,   1'b0);
      chk({tag, "_busy"},     busy,       1'b0);
      chk({tag, "_tx_level"}, tx_level,   7'd0);
      chk({tag, "_rx_level"}, rx_level,   7'd0);
   endtask

   initial begin
      int          p0;
      int          w;
      logic [6:0]  rxl0;
      logic [31:0] d;

      rst        = 1'b1;
      tx_valid   = 1'b0;
      tx_data    = '0;
      tx_fast    = 1'b0;
      rx_ready   = 1'b0;
      flush      = 1'b0;
      spi_dataRx = '0;
      spi_rdy    = 1'b1;
      step();
      step();
      check_reset_values("reset");
      rst = 1'b0;
      step();

      // ---- single 8-bit word, reply 0x3C ----
      p0 = n_pulse;
      wr(32'h0000_00A5, 1'b0);
      xfer("single", 32'h0000_003C, 3);
      chk("single_pulses", 33'(n_pulse - p0), 33'd1);
      chk("single_busy", busy, 1'b0);
`ifdef SPI_BURST_RXFIFO_EN
      chk("single_rx_valid", rx_valid, 1'b1);
      chk("single_rx_data",  rx_data,  32'h0000_003C);
      chk("single_rx_level", rx_level, 7'd1);
`else
      chk("single_rx_valid", rx_valid, 1'b0);
      chk("single_rx_data",  rx_data,  32'h0);
      chk("single_rx_level", rx_level, 7'd0);
`endif
      rx_ready = 1'b1;
      step();
      rx_ready = 1'b0;
      chk("single_rx_drained", rx_level, 7'd0);

      // ---- back-to-back: IDLE for one edge, then ISSUE ----
      wr(32'h1111_2222, 1'b1);
      wr(32'h3333_4444, 1'b0);
      xfer("b2b_a", 32'hAAAA_0001, 2);
      chk("b2b_idle_gap", spi_start, 1'b0);
      xfer("b2b_b", 32'hAAAA_0002, 2);
      chk("b2b_wait", 33'(last_wait), 33'd1);
      rx_ready = 1'b1;
      step();
      step();
      rx_ready = 1'b0;

      // ---- fill TX with 9 words while the shifter is not ready ----
      spi_rdy = 1'b0;
      for (int i = 0; i < 9; i++) begin
         d        = 32'hC0DE_0000 | 32'(i * 32'h0000_0111);
         tx_valid = 1'b1;
         tx_data  = d;
         tx_fast  = d[4];
         chk("fill_ready", tx_ready, (i < 8) ? 1'b1 : 1'b0);
         if (i < 8) sb_q.push_back({d[4], d});
         step();
      end
      tx_valid = 1'b0;
      chk("fill_tx_ready", tx_ready, 1'b0);
      chk("fill_tx_level", tx_level, 7'd8);
      chk("fill_busy",     busy,     1'b1);
      p0 = n_pulse;
      repeat (5) step();
      chk("fill_no_issue", 33'(n_pulse - p0), 33'd0);

      spi_rdy = 1'b1;
      p0 = n_pulse;
      for (int i = 0; i < 8; i++) begin
         xfer("drain", 32'h5000_0000 | 32'(i), 1);
      end
      chk("drain_pulses",   33'(n_pulse - p0), 33'd8);
      chk("drain_sb_empty", 33'(sb_q.size()),  33'd0);
      chk("drain_tx_level", tx_level,          7'd0);
      chk("drain_busy",     busy,              1'b0);

      // ---- 9th word against the RX FIFO ----
`ifdef SPI_BURST_RXFIFO_EN
      chk("rxfull_level", rx_level, 7'd8);
      p0 = n_pulse;
      wr(32'h9999_0009, 1'b1);
      repeat (10) step();
      chk("rxfull_stall_pulses", 33'(n_pulse - p0), 33'd0);
      chk("rxfull_tx_level",     tx_level,          7'd1);
      rx_ready = 1'b1;
      step();
      rx_ready = 1'b0;
      xfer("rxfull_resume", 32'h6000_0009, 1);
      chk("rxfull_after", rx_level, 7'd8);
      rx_ready = 1'b1;
      repeat (8) step();
      rx_ready = 1'b0;
      chk("rxfull_drained", rx_level, 7'd0);
`else
      wr(32'h9999_0009, 1'b1);
      xfer("norx_extra", 32'h6000_0009, 1);
      chk("norx_rx_valid", rx_valid, 1'b0);
      chk("norx_rx_level", rx_level, 7'd0);
`endif

      // ---- flush during WAIT_HI with 3 words still queued ----
      spi_rdy = 1'b0;
      wr(32'hF100_0001, 1'b1);
      wr(32'hF100_0002, 1'b0);
      wr(32'hF100_0003, 1'b1);
      wr(32'hF100_0004, 1'b0);
      spi_rdy = 1'b1;
      wait_issue("flush");
      spi_rdy = 1'b0;
      step();
      step();
      chk("flush_pre_busy",  busy,     1'b1);
      chk("flush_pre_level", tx_level, 7'd3);
      rxl0  = rx_level;
      flush = 1'b1;
      step();
      flush = 1'b0;
      sb_q.delete();
      chk("flush_tx_level",  tx_level, 7'd0);
      chk("flush_busy_xfer", busy,     1'b1);
      spi_dataRx = 32'hDEAD_BEEF;
      spi_rdy    = 1'b1;
      step();
      chk("flush_rx_level", rx_level, rxl0);
      chk("flush_rx_valid", rx_valid, 1'b0);
      chk("flush_busy",     busy,     1'b0);
      p0 = n_pulse;
      repeat (8) step();
      chk("flush_no_issue", 33'(n_pulse - p0), 33'd0);

      // flush wins over a push in the same cycle
      tx_valid = 1'b1;
      tx_data  = 32'h7777_7777;
      flush    = 1'b1;
      step();
      tx_valid = 1'b0;
      flush    = 1'b0;
      chk("flush_push_level", tx_level, 7'd0);
      chk("flush_push_busy",  busy,     1'b0);

      // ---- reset while in WAIT_LO ----
      wr(32'h0BAD_F00D, 1'b1);
      wait_issue("rstmid");
      spi_rdy = 1'b0;
      step();
      chk("rstmid_busy", busy, 1'b1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_reset_values("rstmid");
      p0 = n_pulse;
      spi_dataRx = 32'h1234_5678;
      spi_rdy    = 1'b1;
      repeat (5) step();
      chk("rstmid_rx_level", rx_level,          7'd0);
      chk("rstmid_no_issue", 33'(n_pulse - p0), 33'd0);
      chk("rstmid_busy_end", busy,              1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/spi_burst.md
SPI_BURST -- requirements
Module: spi_burst

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries per direction, power of two, 2..64.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports tx_valid input 1, tx_ready output 1, tx_data input 32, tx_fast input 1: host write channel; word plus mode flag (1 = 32-bit, 0 = 8-bit).
REQ-005 SHALL have ports rx_valid output 1, rx_ready input 1, rx_data output 32: host read channel.
REQ-006 SHALL have port flush  input  1  discard contents of both FIFOs.
REQ-007 SHALL have ports busy output 1, tx_level output 7, rx_level output 7: status.
REQ-008 SHALL have ports spi_start output 1, spi_fast output 1, spi_dataTx output 32, spi_dataRx input 32, spi_rdy input 1: SPI shifter side.

Function
REQ-009 SHALL push {tx_fast,tx_data} into the TX FIFO when tx_valid and tx_ready; tx_ready = TX FIFO not full.
REQ-010 SHALL present the RX FIFO head on rx_data with rx_valid = RX FIFO not empty; pop on rx_valid and rx_ready.
REQ-011 SHALL implement FSM IDLE, ISSUE, WAIT_LO, WAIT_HI.
REQ-012 IDLE->ISSUE when TX FIFO non-empty, spi_rdy=1 and RX FIFO not full; pop TX head into spi_dataTx/spi_fast registers on that edge.
REQ-013 ISSUE SHALL assert spi_start for exactly one cycle, then go to WAIT_LO.
REQ-014 WAIT_LO->WAIT_HI when spi_rdy=0; WAIT_HI->IDLE when spi_rdy=1, pushing spi_dataRx into RX FIFO on that edge.
REQ-015 spi_fast and spi_dataTx SHALL stay constant from ISSUE until return to IDLE.
REQ-016 Back-to-back: next ISSUE no earlier than 2 cycles after completing WAIT_HI (IDLE reached, then ISSUE).
REQ-017 busy SHALL be 1 whenever FSM is not IDLE or TX FIFO is non-empty.
REQ-018 Levels SHALL count 0..DEPTH; simultaneous push and pop on one FIFO leaves level unchanged, pointers wrap modulo DEPTH.
REQ-019 Push when full or pop when empty SHALL be ignored (no pointer/level change).
REQ-020 flush SHALL zero both FIFOs next cycle; an in-flight transfer completes on the SPI side but its result is not pushed; flush wins over simultaneous push.

Reset
REQ-021 On rst: FSM IDLE, spi_start 0, spi_fast 0, spi_dataTx 0, FIFOs empty, tx_ready 1, rx_valid 0, busy 0, levels 0.
REQ-022 Reset mid-transfer SHALL abandon the transfer; no RX push occurs.

Configuration
REQ-023 With SPI_BURST_RXFIFO_EN defined: RX FIFO and REQ-010/REQ-012 rx-full stall as above.
REQ-024 Without SPI_BURST_RXFIFO_EN: no RX FIFO instantiated, received words discarded, rx_valid=0, rx_data=0, rx_level=0, no rx-full stall; ports retained.

Structure
REQ-025 Package spi_burst_pkg SHALL hold FSM state encoding, word width 32, default DEPTH.
REQ-026 SHALL use sub-module spi_burst_fifo (parameterised width/depth, level output), instantiated for TX (33-bit) and RX (32-bit).

Verification
REQ-027 Write 0xA5 fast=0, model shifter returns 0x3C -> one spi_start pulse, spi_fast=0, rx_data=0x0000003C, rx_level=1.
REQ-028 Write 8 words fast=1 with rx_ready=0 (DEPTH=8) -> 8 transfers, rx_level=8; 9th queued word stalls in TX FIFO, tx_level=1, until one RX pop.
REQ-029 Write 9 words without issuing (spi_rdy held 0) -> tx_ready=0 after 8th, 9th ignored, tx_level=8.
REQ-030 flush asserted during WAIT_HI with 3 TX words queued -> tx_level=0, current result not pushed, rx_level unchanged, FSM returns IDLE, busy=0.
REQ-031 rst asserted in WAIT_LO -> next cycle all outputs at REQ-021 values; no RX push on later spi_rdy rise.
REQ-032 Build without SPI_BURST_RXFIFO_EN, send 4 words -> 4 transfers, rx_valid stays 0, rx_level 0.
